chip8_alu_seq: RTL



---
 rtl/chip8_alu_seq_if.sv | 23 ++
 rtl/chip8_alu_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/chip8_alu_seq_if.sv
// Opcode handshake and V-register-file port bundle for the CHIP-8 execute stage.
// The slave modport is the execute stage; the master modport is its environment.
interface chip8_alu_seq_if;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic        rf_wren;
  logic [7:0]  rf_rdata;
  logic        done;
  logic        illegal;

  modport slave (
    input  op_valid, op, rf_rdata,
    output op_ready, rf_addr, rf_wdata, rf_wren, done, illegal
  );

  modport master (
    output op_valid, op, rf_rdata,
    input  op_ready, rf_addr, rf_wdata, rf_wren, done, illegal
  );
endinterface

// File: rtl/chip8_alu_seq.sv
// Multi-cycle CHIP-8 execute stage for 6XNN, 7XNN and 8XYN over a single-port V-register file.
// Optional feature macro CHIP8_VF_RESET_EN: 8XY1/8XY2/8XY3 also clear VF (COSMAC behaviour).
module chip8_alu_seq (
  input  logic             clk,
  input  logic             rst,
  chip8_alu_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_X,
    S_RD_Y,
    S_WR_X,
    S_WR_F
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] op_q, op_d;
  logic [7:0]  vx_q, vx_d;
  logic [7:0]  vy_q, vy_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;

  logic        op_ready;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wdata;
  logic        rf_wren;

  logic [3:0]  x_idx, y_idx, n_fn;
  logic [7:0]  nn;
  logic [8:0]  sum9;
  logic [7:0]  result;
  logic        flag;

  function automatic logic is_legal(input logic [15:0] o);
    unique case (o[15:12])
      4'h6, 4'h7: is_legal = 1'b1;
      4'h8:       is_legal = (o[3] == 1'b0) || (o[3:0] == 4'hE);
      default:    is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic writes_flag(input logic [15:0] o);
    writes_flag = 1'b0;
    if (o[15:12] == 4'h8) begin
      unique case (o[3:0])
        4'h4, 4'h5, 4'h6, 4'h7, 4'hE: writes_flag = 1'b1;
`ifdef CHIP8_VF_RESET_EN
        4'h1, 4'h2, 4'h3:             writes_flag = 1'b1;
`endif
        default:                      writes_flag = 1'b0;
      endcase
    end
  endfunction

  assign x_idx = op_q[11:8];
  assign y_idx = op_q[7:4];
  assign n_fn  = op_q[3:0];
  assign nn    = op_q[7:0];
  assign sum9  = {1'b0, vx_q} + {1'b0, vy_q};

  // Result and flag both come from the captured pre-write vx/vy, so a write to
  // VF in WR_X cannot disturb the flag written afterwards in WR_F.
  always_comb begin
    result = 8'h00;
    flag   = 1'b0;
    unique case (op_q[15:12])
      4'h6: result = nn;
      4'h7: result = vx_q + nn;
      4'h8: begin
        unique case (n_fn)
          4'h0: result = vy_q;
          4'h1: result = vx_q | vy_q;
          4'h2: result = vx_q & vy_q;
          4'h3: result = vx_q ^ vy_q;
          4'h4: begin result = sum9[7:0];     flag = sum9[8];        end
          4'h5: begin result = vx_q - vy_q;   flag = (vx_q >= vy_q); end
          4'h6: begin result = vx_q >> 1;     flag = vx_q[0];        end
          4'h7: begin result = vy_q - vx_q;   flag = (vy_q >= vx_q); end
          4'hE: begin result = vx_q << 1;     flag = vx_q[7];        end
          default: begin result = 8'h00;      flag = 1'b0;           end
        endcase
      end
      default: result = 8'h00;
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    op_ready  = 1'b0;
    rf_addr   = 4'h0;
    rf_wdata  = 8'h00;
    rf_wren   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (bus.op_valid) begin
          op_d = bus.op;
          if (!is_legal(bus.op)) begin
            done_d    = 1'b1;
            illegal_d = 1'b1;
          end else if (bus.op[15:12] == 4'h6) begin
            state_d = S_WR_X;
          end else begin
            state_d = S_RD_X;
          end
        end
      end
      S_RD_X: begin
        rf_addr = x_idx;
        vx_d    = bus.rf_rdata;
        state_d = (op_q[15:12] == 4'h7) ? S_WR_X : S_RD_Y;
      end
      S_RD_Y: begin
        rf_addr = y_idx;
        vy_d    = bus.rf_rdata;
        state_d = S_WR_X;
      end
      S_WR_X: begin
        rf_addr  = x_idx;
        rf_wren  = 1'b1;
        rf_wdata = result;
        if (writes_flag(op_q)) begin
          state_d = S_WR_F;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_WR_F: begin
        rf_addr  = 4'hF;
        rf_wren  = 1'b1;
        rf_wdata = {7'b0, flag};
        state_d  = S_IDLE;
        done_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset is synchronous, so the state may still be mid-instruction on a reset
    // edge; quiet the port here so nothing is written while rst is high.
    if (rst) begin
      op_ready = 1'b0;
      rf_addr  = 4'h0;
      rf_wdata = 8'h00;
      rf_wren  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // NOTE: the opcode and operand latches carry no reset; they are always
  // reloaded before use, so a reset on them would only cost routing.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    vx_q <= vx_d;
    vy_q <= vy_d;
  end

  assign bus.op_ready = op_ready;
  assign bus.rf_addr  = rf_addr;
  assign bus.rf_wdata = rf_wdata;
  assign bus.rf_wren  = rf_wren;
  assign bus.done     = done_q;
  assign bus.illegal  = illegal_q;

endmodule
